sseg_scan_mux: RTL and testbench

//  Time-multiplexed driver for a NUM_DIGITS common-anode/cathode 7-seg bank.

---
 rtl/sseg_pkg.sv | 28 ++
 rtl/sseg_glyph_decode.sv | 32 +++
 rtl/sseg_scan_mux.sv | 148 ++++++++++++++
 tb/tb_sseg_scan_mux.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared glyph codes and scanner state encoding for the 7-segment scan driver.
// Glyphs are active-high, bit 6 = segment a ... bit 0 = segment g.
package sseg_pkg;

    localparam logic [6:0] G_0   = 7'b1111110;
    localparam logic [6:0] G_1   = 7'b0110000;
    localparam logic [6:0] G_2   = 7'b1101101;
    localparam logic [6:0] G_3   = 7'b1111001;
    localparam logic [6:0] G_4   = 7'b0110011;
    localparam logic [6:0] G_5   = 7'b1011011;
    localparam logic [6:0] G_6   = 7'b1011111;
    localparam logic [6:0] G_7   = 7'b1110000;
    localparam logic [6:0] G_8   = 7'b1111111;
    localparam logic [6:0] G_9   = 7'b1111011;
    localparam logic [6:0] G_A   = 7'b1110111;
    localparam logic [6:0] G_O   = 7'b0011101;
    localparam logic [6:0] G_H   = 7'b0110111;
    localparam logic [6:0] G_D   = 7'b0111101;
    localparam logic [6:0] G_E   = 7'b1001111;
    localparam logic [6:0] G_OFF = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_e;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Nibble to active-high 7-segment glyph. Sole owner of the glyph table.
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    // Full 16-entry table; 0xF is the blank code.
    always_comb begin
        glyph_o = G_OFF;
        unique case (nibble_i)
            4'h0: glyph_o = G_0;
            4'h1: glyph_o = G_1;
            4'h2: glyph_o = G_2;
            4'h3: glyph_o = G_3;
            4'h4: glyph_o = G_4;
            4'h5: glyph_o = G_5;
            4'h6: glyph_o = G_6;
            4'h7: glyph_o = G_7;
            4'h8: glyph_o = G_8;
            4'h9: glyph_o = G_9;
            4'hA: glyph_o = G_A;
            4'hB: glyph_o = G_O;
            4'hC: glyph_o = G_H;
            4'hD: glyph_o = G_D;
            4'hE: glyph_o = G_E;
            4'hF: glyph_o = G_OFF;
        endcase
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 7-segment bank driver: per-slot ghost-blank gap, frame
// snapshot of the display inputs, leading-zero blanking and pin polarity.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYC      = 16,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dots_i,
    input  logic                    lz_en_i,
    input  logic                    enable_i,
    output logic [6:0]              sseg_o,
    output logic                    dot_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_tick_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Pin-level "off" patterns; XOR with these applies polarity.
    localparam logic [6:0]            SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DotOff = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AnOff  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    state_e                         state_q;
    logic [CntW-1:0]                cnt_q;
    logic [IdxW-1:0]                idx_q;
    logic [NUM_DIGITS-1:0][3:0]     snap_val_q;
    logic [NUM_DIGITS-1:0]          snap_dots_q;
    logic                           snap_lz_q;
    logic [6:0]                     sseg_q;
    logic                           dot_q;
    logic [NUM_DIGITS-1:0]          an_q;
    logic                           frame_tick_q;

    logic [NUM_DIGITS-1:0]          lz_blank;
    logic                           lead;
    logic [3:0]                     cur_nib;
    logic [6:0]                     dec_glyph;
    logic [6:0]                     drv_seg;
    logic                           drv_dot;
    logic [NUM_DIGITS-1:0]          drv_an;

    // Leading-zero mask: walk down from the MSD while nibbles are 0 and no dot seen.
    always_comb begin
        lead     = 1'b1;
        lz_blank = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            lead        = lead & (snap_val_q[k] == 4'h0) & ~snap_dots_q[k];
            lz_blank[k] = snap_lz_q & lead & (k != 0);
        end
    end

    assign cur_nib = snap_val_q[idx_q];

    sseg_glyph_decode u_decode (
        .nibble_i (cur_nib),
        .glyph_o  (dec_glyph)
    );

    // Pin values for the digit about to be driven (dot ignores blanking).
    always_comb begin
        drv_seg = (lz_blank[idx_q] ? G_OFF : dec_glyph) ^ SegOff;
        drv_dot = snap_dots_q[idx_q] ^ DotOff;
        drv_an  = (NUM_DIGITS'(1) << idx_q) ^ AnOff;
    end

    // Scanner FSM with counters, frame snapshot and registered pin outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_val_q   <= '0;
            snap_dots_q  <= '0;
            snap_lz_q    <= 1'b0;
            sseg_q       <= SegOff;
            dot_q        <= DotOff;
            an_q         <= AnOff;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            if (!enable_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
                sseg_q  <= SegOff;
                dot_q   <= DotOff;
                an_q    <= AnOff;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_BLANK;
                        cnt_q        <= '0;
                        idx_q        <= '0;
                        snap_val_q   <= value_i;
                        snap_dots_q  <= dots_i;
                        snap_lz_q    <= lz_en_i;
                        frame_tick_q <= 1'b1;
                    end
                    ST_BLANK: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(BLANK_CYC - 1)) begin
                            state_q <= ST_DRIVE;
                            sseg_q  <= drv_seg;
                            dot_q   <= drv_dot;
                            an_q    <= drv_an;
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt_q == CntW'(SCAN_DIV - 1)) begin
                            state_q <= ST_BLANK;
                            cnt_q   <= '0;
                            sseg_q  <= SegOff;
                            dot_q   <= DotOff;
                            an_q    <= AnOff;
                            if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
                                idx_q        <= '0;
                                snap_val_q   <= value_i;
                                snap_dots_q  <= dots_i;
                                snap_lz_q    <= lz_en_i;
                                frame_tick_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sseg_o       = sseg_q;
    assign dot_o        = dot_q;
    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux: two instances (segment polarity high/low)
// share stimulus; expected pin values come from hand-computed glyph tables.
module tb_sseg_scan_mux;

    localparam int N = 4;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dots;
        logic            lz;
        logic [3:0][6:0] seg;   // expected active-high glyph, index = digit
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dots = '0;
    logic        lz_en = 1'b0;
    logic        enable = 1'b0;

    logic [6:0]   sseg_a, sseg_b;
    logic         dot_a, dot_b, tick_a, tick_b;
    logic [N-1:0] an_a, an_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .NUM_DIGITS(N), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dots_i(dots), .lz_en_i(lz_en),
        .enable_i(enable), .sseg_o(sseg_a), .dot_o(dot_a), .an_o(an_a), .frame_tick_o(tick_a)
    );

    sseg_scan_mux #(
        .NUM_DIGITS(N), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .dots_i(dots), .lz_en_i(lz_en),
        .enable_i(enable), .sseg_o(sseg_b), .dot_o(dot_b), .an_o(an_b), .frame_tick_o(tick_b)
    );

    // Packed as {an, sseg, dot, frame_tick}.
    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got an/sseg/dot/tick=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick_();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string name);
        check({name, " pos"}, {an_a, sseg_a, dot_a, tick_a}, {4'hF, 7'h00, 1'b0, 1'b0});
        check({name, " neg"}, {an_b, sseg_b, dot_b, tick_b}, {4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    // Cycle c = state after the c-th edge following enable; 32 cycles per frame.
    task automatic check_cycle(input int c, input logic [3:0][6:0] seg, input logic [3:0] dts);
        int pos, k, cn;
        logic [3:0] an_e;
        logic [6:0] s_e;
        logic       d_e, t_e;
        pos = (c - 1) % 32;
        k   = pos / 8;
        cn  = pos % 8;
        t_e = (pos == 0);
        if (cn >= 2) begin
            an_e = ~(4'b0001 << k);
            s_e  = seg[k];
            d_e  = dts[k];
        end else begin
            an_e = 4'hF;
            s_e  = 7'h00;
            d_e  = 1'b0;
        end
        check($sformatf("cyc%0d pos", c), {an_a, sseg_a, dot_a, tick_a}, {an_e, s_e, d_e, t_e});
        check($sformatf("cyc%0d neg", c), {an_b, sseg_b, dot_b, tick_b}, {an_e, ~s_e, ~d_e, t_e});
    endtask

    task automatic run(input int c0, input int c1, input logic [3:0][6:0] seg,
                       input logic [3:0] dts);
        for (int c = c0; c <= c1; c++) begin
            tick_();
            check_cycle(c, seg, dts);
        end
    endtask

    // Park the scanner, load new inputs, re-enable so the next edge starts a frame.
    task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic lz);
        enable = 1'b0;
        tick_();
        check_dark("parked");
        value  = v;
        dots   = d;
        lz_en  = lz;
        enable = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        // seg[3..0] written MSD first.
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{16'h0005, 4'b0010, 1'b1, {7'b0000000, 7'b0000000, 7'b1111110, 7'b1011011}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[3] = '{16'hDCBA, 4'b1010, 1'b0, {7'b0111101, 7'b0110111, 7'b0011101, 7'b1110111}};
        vecs[4] = '{16'h5FE0, 4'b0000, 1'b1, {7'b1011011, 7'b0000000, 7'b1001111, 7'b1111110}};
        vecs[5] = '{16'h0709, 4'b0000, 1'b1, {7'b0000000, 7'b1110000, 7'b1111110, 7'b1111011}};
        vecs[6] = '{16'h0068, 4'b0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1011111, 7'b1111111}};
        vecs[7] = '{16'h0000, 4'b0100, 1'b1, {7'b0000000, 7'b1111110, 7'b1111110, 7'b1111110}};

        // Reset state.
        #12;
        check_dark("reset");
        rst_n = 1'b1;
        tick_();
        check_dark("idle");

        // Table of full frames, each followed by the next frame's tick.
        for (int i = 0; i < 8; i++) begin
            restart(vecs[i].value, vecs[i].dots, vecs[i].lz);
            run(1, 33, vecs[i].seg, vecs[i].dots);
        end

        // Asynchronous reset in the middle of a DRIVE slot, then restart.
        restart(16'h1234, 4'b0000, 1'b0);
        run(1, 5, vecs[0].seg, 4'b0000);
        #2 rst_n = 1'b0;
        #1 check_dark("async reset");
        #2 rst_n = 1'b1;
        run(1, 10, vecs[0].seg, 4'b0000);

        // Snapshot: value changes while digit 1 is scanning; shown next frame only.
        restart(16'h1111, 4'b0000, 1'b0);
        run(1, 12, {4{7'b0110000}}, 4'b0000);
        value = 16'h2222;
        run(13, 32, {4{7'b0110000}}, 4'b0000);
        run(33, 64, {4{7'b1101101}}, 4'b0000);

        // enable drop mid-slot: dark next cycle, restart at digit 0 with a tick.
        restart(16'h1234, 4'b0001, 1'b0);
        run(1, 20, vecs[0].seg, 4'b0001);
        enable = 1'b0;
        tick_();
        check_dark("enable drop");
        tick_();
        check_dark("still parked");
        enable = 1'b1;
        run(1, 12, vecs[0].seg, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
